// File: rtl/fp32_pkg.sv
// Shared constants, FSM state type and shift-count helper for the
// FP32 to INT32 converter.
package fp32_pkg;

    localparam int          MANT_W          = 23;
    localparam logic [7:0]  EXP_BIAS        = 8'd127;
    localparam logic [7:0]  EXP_INF         = 8'd255;
    // Smallest exponent whose magnitude no longer fits in int32 (2^31).
    localparam logic [7:0]  EXP_BIG         = 8'd158;
    // Exponent at which {1, mantissa} already equals the integer value.
    localparam logic [7:0]  EXP_UNITY_SHIFT = 8'd150;
    localparam logic [31:0] INT32_MAX       = 32'h7FFF_FFFF;
    localparam logic [31:0] INT32_MIN       = 32'h8000_0000;
    // -2^31 exactly: the one big-exponent input that is representable.
    localparam logic [31:0] FP_NEG_2P31     = 32'hCF00_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_OUT   = 2'd2
    } conv_state_e;

    // |exp - 150| for exponents 127..157; the difference is below 32, so the
    // low five bits carry it exactly with modular arithmetic (150 mod 32 = 22).
    function automatic logic [4:0] shift_count(input logic [7:0] exp_val);
        logic [4:0] cnt_v;
        if (exp_val >= EXP_UNITY_SHIFT) begin
            cnt_v = exp_val[4:0] - 5'd22;
        end else begin
            cnt_v = 5'd22 - exp_val[4:0];
        end
        return cnt_v;
    endfunction

endpackage

// File: rtl/fp32_unpack.sv
// Combinational split of an IEEE-754 single into its fields plus the
// classifications the converter needs to pick a special-case result.
module fp32_unpack
    import fp32_pkg::*;
(
    input  logic [31:0]       fp,
    output logic              sign,
    output logic [7:0]        exp,
    output logic [MANT_W-1:0] mant,
    output logic              is_nan,
    output logic              is_inf,
    output logic              is_small,
    output logic              is_big
);

    logic mant_nz_s;

    // Field extraction and range classification.
    always_comb begin
        sign      = fp[31];
        exp       = fp[30:23];
        mant      = fp[MANT_W-1:0];
        mant_nz_s = (fp[MANT_W-1:0] != 23'd0);
        is_nan    = (fp[30:23] == EXP_INF) && mant_nz_s;
        is_inf    = (fp[30:23] == EXP_INF) && !mant_nz_s;
        is_small  = (fp[30:23] < EXP_BIAS);
        is_big    = (fp[30:23] >= EXP_BIG);
    end

endmodule

// File: rtl/fp32_to_int32_converter.sv
// Iterative FP32 to INT32 conversion with truncation toward zero. Special
// inputs resolve on the accepting edge; normal inputs shift the 24-bit
// significand one position per cycle until it is aligned to the binary point.
module fp32_to_int32_converter
    import fp32_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_fp,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_int,
    output logic        out_invalid,
    output logic        out_inexact
);

    conv_state_e       state_r;
    conv_state_e       next_state_s;

    logic              sign_s;
    logic [7:0]        exp_s;
    logic [MANT_W-1:0] mant_s;
    logic              is_nan_s;
    logic              is_inf_s;
    logic              is_small_s;
    logic              is_big_s;
    logic              special_s;
    logic              accept_s;

    logic              sign_r;
    logic              left_r;
    logic              sticky_r;
    logic [4:0]        cnt_r;
    logic [31:0]       mag_r;
    logic [31:0]       out_int_r;
    logic              out_invalid_r;
    logic              out_inexact_r;

    fp32_unpack u_unpack (
        .fp       (in_fp),
        .sign     (sign_s),
        .exp      (exp_s),
        .mant     (mant_s),
        .is_nan   (is_nan_s),
        .is_inf   (is_inf_s),
        .is_small (is_small_s),
        .is_big   (is_big_s)
    );

    assign special_s   = is_nan_s | is_inf_s | is_small_s | is_big_s;
    assign accept_s    = in_valid && (state_r == ST_IDLE);
    assign in_ready    = (state_r == ST_IDLE);
    assign out_valid   = (state_r == ST_OUT);
    assign out_int     = out_int_r;
    assign out_invalid = out_invalid_r;
    assign out_inexact = out_inexact_r;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode: specials skip straight to OUT, OUT waits for the consumer.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    if (special_s) begin
                        next_state_s = ST_OUT;
                    end else begin
                        next_state_s = ST_SHIFT;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (cnt_r == 5'd0) begin
                    next_state_s = ST_OUT;
                end else begin
                    next_state_s = ST_SHIFT;
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_OUT;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Operand capture, alignment shifting and result/flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_r        <= 1'b0;
            left_r        <= 1'b0;
            sticky_r      <= 1'b0;
            cnt_r         <= 5'd0;
            mag_r         <= 32'd0;
            out_int_r     <= 32'd0;
            out_invalid_r <= 1'b0;
            out_inexact_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        sign_r   <= sign_s;
                        mag_r    <= {8'b0, 1'b1, mant_s};
                        sticky_r <= 1'b0;
                        left_r   <= (exp_s >= EXP_UNITY_SHIFT);
                        cnt_r    <= 5'd0;
                        if (is_nan_s || is_inf_s) begin
                            out_int_r     <= INT32_MIN;
                            out_invalid_r <= 1'b1;
                            out_inexact_r <= 1'b0;
                        end else if (is_small_s) begin
                            out_int_r     <= 32'd0;
                            out_invalid_r <= 1'b0;
                            out_inexact_r <= (in_fp[30:0] != 31'd0);
                        end else if (is_big_s) begin
                            out_inexact_r <= 1'b0;
                            if (in_fp == FP_NEG_2P31) begin
                                out_int_r     <= INT32_MIN;
                                out_invalid_r <= 1'b0;
                            end else begin
                                out_int_r     <= sign_s ? INT32_MIN : INT32_MAX;
                                out_invalid_r <= 1'b1;
                            end
                        end else begin
                            cnt_r <= shift_count(exp_s);
                        end
                    end
                end
                ST_SHIFT: begin
                    if (cnt_r != 5'd0) begin
                        cnt_r <= cnt_r - 5'd1;
                        if (left_r) begin
                            mag_r <= {mag_r[30:0], 1'b0};
                        end else begin
                            mag_r    <= {1'b0, mag_r[31:1]};
                            sticky_r <= sticky_r | mag_r[0];
                        end
                    end else begin
                        out_int_r     <= sign_r ? (32'd0 - mag_r) : mag_r;
                        out_invalid_r <= 1'b0;
                        out_inexact_r <= sticky_r;
                    end
                end
                ST_OUT: begin
                    out_int_r <= out_int_r;
                end
                default: begin
                    cnt_r <= 5'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp32_to_int32_converter.sv
// Self-checking bench for fp32_to_int32_converter: a vector table driven
// through a scoreboard queue, plus backpressure and mid-conversion reset.
module tb_fp32_to_int32_converter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_fp = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_int;
    logic        out_invalid;
    logic        out_inexact;

    typedef struct {
        logic [31:0] fp;
        logic [31:0] res;
        logic        inv;
        logic        inx;
        int          lat;   // rising edges after the accepting edge until out_valid is seen
    } vec_t;

    vec_t vecs[13];
    vec_t sb_q[$];
    int   total = 0;
    int   bad = 0;

    fp32_to_int32_converter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_fp       (in_fp),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_int     (out_int),
        .out_invalid (out_invalid),
        .out_inexact (out_inexact)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Present one operand, record its expectation, scramble in_fp afterwards.
    task automatic issue(input vec_t v);
        int guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("in_ready_before_issue", {31'd0, in_ready}, 32'd1);
        in_fp    = v.fp;
        in_valid = 1'b1;
        sb_q.push_back(v);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_fp    = $urandom;
    endtask

    // Wait for a result, pop the expectation and compare; returns with result consumed.
    task automatic collect(input string tag);
        int   lat = 0;
        vec_t e;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!out_valid) begin
            check({tag, "_timeout"}, 32'd0, 32'd1);
        end else if (sb_q.size() == 0) begin
            check({tag, "_unexpected_result"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check({tag, "_int"}, out_int, e.res);
            check({tag, "_invalid"}, {31'd0, out_invalid}, {31'd0, e.inv});
            check({tag, "_inexact"}, {31'd0, out_inexact}, {31'd0, e.inx});
            check({tag, "_latency"}, lat, e.lat);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v;
        vec_t held;
        int   seen_valid;

        vecs[0]  = '{32'h3FC0_0000, 32'h0000_0001, 1'b0, 1'b1, 24};  // 1.5
        vecs[1]  = '{32'hC2F6_0000, 32'hFFFF_FF85, 1'b0, 1'b0, 18};  // -123.0
        vecs[2]  = '{32'h4EFF_FFFF, 32'h7FFF_FF80, 1'b0, 1'b0, 8};   // left shift by 7
        vecs[3]  = '{32'hCF00_0000, 32'h8000_0000, 1'b0, 1'b0, 0};   // -2^31 exact
        vecs[4]  = '{32'h4F00_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 0};   // +2^31 overflow
        vecs[5]  = '{32'h7FC0_0000, 32'h8000_0000, 1'b1, 1'b0, 0};   // NaN
        vecs[6]  = '{32'hFF80_0000, 32'h8000_0000, 1'b1, 1'b0, 0};   // -inf
        vecs[7]  = '{32'h3F00_0000, 32'h0000_0000, 1'b0, 1'b1, 0};   // 0.5
        vecs[8]  = '{32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0, 0};   // -0
        vecs[9]  = '{32'h4B00_0000, 32'h0080_0000, 1'b0, 1'b0, 1};   // 2^23, no shift
        vecs[10] = '{32'hC020_0000, 32'hFFFF_FFFE, 1'b0, 1'b1, 23};  // -2.5
        vecs[11] = '{32'h0000_0001, 32'h0000_0000, 1'b0, 1'b1, 0};   // smallest denormal
        vecs[12] = '{32'hCF00_0001, 32'h8000_0000, 1'b1, 1'b0, 0};   // just below -2^31

        repeat (3) @(negedge clk);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_out_int", out_int, 32'd0);
        check("reset_flags", {30'd0, out_invalid, out_inexact}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);

        for (int i = 0; i < 13; i++) begin
            issue(vecs[i]);
            collect($sformatf("vec%0d", i));
        end

        // Backpressure: result must hold for 5 stalled cycles, then drain.
        out_ready = 1'b0;
        v = '{32'h4F00_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 0};
        issue(v);
        check("bp_valid", {31'd0, out_valid}, 32'd1);
        held = sb_q.pop_front();
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("bp_hold_valid%0d", k), {31'd0, out_valid}, 32'd1);
            check($sformatf("bp_hold_int%0d", k), out_int, held.res);
            check($sformatf("bp_hold_flags%0d", k), {30'd0, out_invalid, out_inexact},
                  {30'd0, held.inv, held.inx});
            check($sformatf("bp_in_ready%0d", k), {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_valid", {31'd0, out_valid}, 32'd0);
        check("bp_release_in_ready", {31'd0, in_ready}, 32'd1);

        // Reset in the middle of shifting discards the operation.
        v = '{32'h3FC0_0000, 32'h0000_0001, 1'b0, 1'b1, 24};
        issue(v);
        repeat (5) @(posedge clk);
        #1;
        check("mid_shift_in_ready", {31'd0, in_ready}, 32'd0);
        rst_n = 1'b0;
        #2;
        sb_q.delete();
        check("rst_async_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_async_out_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_valid = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen_valid++;
        end
        check("rst_no_result", seen_valid, 0);
        v = '{32'h4040_0000, 32'h0000_0003, 1'b0, 1'b0, 23};
        issue(v);
        collect("after_reset");

        check("scoreboard_empty", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
